fpu_result_buffer: RTL and testbench
====================================

// Module: fpu_result_buffer
// PURPOSE
//  Stage directly downstream of the FPU (custom 32-bit float: 1 sign | 10 exp, bias 511 | 21 mantissa).
//  - Captures each {data_out, status_out} result pulse into a first-word-fall-through (FWFT) FIFO.
//  - Consumers drain results with a valid/ready handshake; results are never stalled back into the FPU.
//  - Optionally keeps saturating per-status and zero-result counters for bench/debug readout.
// PARAMETERS
//  DATA_W    32  result word width
//  STATUS_W  4   status width; codes OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3
//  DEPTH     8   FIFO entries; power of two, >=2
//  CNT_W     16  statistics counter width
// PORTS
//  clock_100Khz  in   1               single clock; all logic on posedge
//  reset         in   1               synchronous, active-high
//  res_valid     in   1               1-cycle pulse: res_data/res_status valid this cycle
//  res_data      in   DATA_W          FPU result word
//  res_status    in   STATUS_W        FPU status code
//  rd_ready      in   1               consumer accepts head entry
//  rd_valid      out  1               head entry valid (= !empty)
//  rd_data       out  DATA_W          head result; 0 when empty
//  rd_status     out  STATUS_W        head status; 0 when empty
//  level         out  $clog2(DEPTH)+1 occupied entries, 0..DEPTH
//  full          out  1               level==DEPTH
//  empty         out  1               level==0
//  drop_err      out  1               sticky: a result was discarded because the FIFO was full
//  clear_err     in   1               clears drop_err
//  cnt_ovf/cnt_unf/cnt_exact/cnt_inexact/cnt_zero  out  CNT_W each  (FPU_RESULT_STATS_EN only)
// BEHAVIOUR
//  - Reset values: level=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_status=0, drop_err=0, counters=0.
//    Pointers are cleared; RAM contents are not cleared but are invisible.
//  - Pop: occurs when rd_valid && rd_ready at a posedge. The read pointer advances and the next entry
//    (if any) appears in the same cycle (FWFT).
//  - Push: res_valid && (!full || pop). Writes at the write pointer, which advances.
//    - Latency: a push at edge N gives rd_valid=1 after edge N when the FIFO was empty. There is no bypass.
//  - Simultaneous push+pop:
//    - when full, both occur and level stays DEPTH;
//    - when empty, there is no pop (rd_valid=0), the push occurs and level becomes 1;
//    - otherwise level is unchanged.
//  - Drop: res_valid && full && !pop. The entry is discarded and drop_err is set. drop_err clears only on
//    clear_err; if a drop and clear_err occur in the same cycle, set wins.
//  - Pointers are log2(DEPTH) bits and wrap naturally. level is tracked separately (DEPTH vs 0 unambiguous).
//  - res_status codes >3 are stored unchanged and increment no status counter.
//  - A reset asserted mid-operation has priority over push/pop that cycle. All outputs return to their
//    reset values after that edge.
// CONFIGURATION
//  FPU_RESULT_STATS_EN defined:
//  - cnt_* ports exist. Each counter increments once per accepted push (drops are not counted),
//    by status code.
//  - cnt_zero increments when res_data[30:0]==0 (either sign).
//  - Counters saturate at all-ones and are cleared only by reset.
//  FPU_RESULT_STATS_EN undefined:
//  - cnt_* ports and their logic are absent; FIFO behaviour is identical.
// TESTING
//  1. Reset, then push 32'h4000_0000 (2.0) with status 2 and rd_ready=0
//     -> next cycle rd_valid=1, rd_data=32'h4000_0000, rd_status=2, level=1.
//  2. 9 pushes without pops (DEPTH=8)
//     -> full=1, level=8, drop_err=1. Draining returns the first 8 words in order, then empty=1.
//     Then clear_err -> drop_err=0.
//  3. Full, then push 32'h4010_0000 (3.0) with rd_ready=1 in the same cycle
//     -> level stays 8, drop_err=0, 3.0 is read last.
//  4. Empty, then res_valid=1 with 32'h3FE0_0000 (1.0) and rd_ready=1 in the same cycle
//     -> no pop, level=1 next cycle, 1.0 read on the following handshake.
//  5. STATS_EN: push 32'h0000_0000/st2, 32'h8000_0000/st2, 32'h7FE0_0000/st0
//     -> cnt_exact=2, cnt_zero=2, cnt_ovf=1, others 0. Force cnt to all-ones
//     -> stays saturated on further pushes.
//  6. Reset with level=5 mid-stream (concurrent push and pop)
//     -> after the edge: empty=1, level=0, rd_valid=0, rd_data=0, drop_err=0, counters=0.

Source files
------------

// File: rtl/fpu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_buffer
// Purpose  : Result buffer placed directly after the FPU. Every result pulse
//            {res_data, res_status} is pushed into a first-word-fall-through
//            FIFO and drained by a consumer over a valid/ready handshake.
//            The FPU is never stalled: a result arriving while the FIFO is
//            full and not popping is dropped, and the sticky drop_err is set.
//            Optional saturating statistics counters, enabled by the
//            FPU_RESULT_STATS_EN macro, count accepted results per status code
//            and count zero results.
// Ports    :
//   clock_100Khz  in   single clock, all logic on the rising edge
//   reset         in   synchronous, active-high
//   res_valid     in   one-cycle result pulse
//   res_data      in   FPU result word (sign | exponent | mantissa)
//   res_status    in   FPU status code (0 ovf, 1 unf, 2 exact, 3 inexact)
//   rd_ready      in   consumer accepts the head entry
//   rd_valid      out  head entry valid (FIFO not empty)
//   rd_data       out  head result word, 0 when empty
//   rd_status     out  head status code, 0 when empty
//   level         out  occupied entries, 0..DEPTH
//   full          out  level == DEPTH
//   empty         out  level == 0
//   drop_err      out  sticky: a result was discarded while full
//   clear_err     in   clears drop_err (a same-cycle drop wins)
//   cnt_ovf, cnt_unf, cnt_exact, cnt_inexact, cnt_zero
//                 out  saturating counters (FPU_RESULT_STATS_EN only)
// Revision : 1.0  initial release
// ============================================================================
module fpu_result_buffer #(
  parameter int DATA_W   = 32,
  parameter int STATUS_W = 4,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                       clock_100Khz,
  input  logic                       reset,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  input  logic [STATUS_W-1:0]        res_status,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [STATUS_W-1:0]        rd_status,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       drop_err,
`ifdef FPU_RESULT_STATS_EN
  output logic [CNT_W-1:0]           cnt_ovf,
  output logic [CNT_W-1:0]           cnt_unf,
  output logic [CNT_W-1:0]           cnt_exact,
  output logic [CNT_W-1:0]           cnt_inexact,
  output logic [CNT_W-1:0]           cnt_zero,
`endif
  input  logic                       clear_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int ENTRY_W = DATA_W + STATUS_W;

  localparam logic [LW-1:0] c_depth = LW'(DEPTH);
  localparam logic [LW-1:0] c_level_one = LW'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  // Pointer wrap relies on DEPTH being a power of two.
  generate
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
      $error("fpu_result_buffer: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic               r_drop_err;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_depth);

  // A pop needs a real head entry, so a push into an empty FIFO is never
  // paired with a pop in the same cycle (no bypass path).
  assign w_pop   = !w_empty && rd_ready;

  // When full, a concurrent pop frees the slot the push lands in.
  assign w_push  = res_valid && (!w_full || w_pop);
  assign w_drop  = res_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // RAM write port. Contents are deliberately not reset; entries outside the
  // occupied window are masked on the read side.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_100Khz) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {res_data, res_status};
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and the sticky drop flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end

      // Occupancy is held separately from the pointers so that full and
      // empty are distinguishable when the pointers are equal.
      if (w_push && !w_pop) begin
        r_level <= r_level + c_level_one;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - c_level_one;
      end

      // A drop in the same cycle as clear_err keeps the flag set.
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end else if (clear_err) begin
        r_drop_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FWFT read side: the head entry is presented combinationally from the RAM
  // and forced to zero while the FIFO is empty.
  // --------------------------------------------------------------------------
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign rd_valid  = !w_empty;
  assign rd_data   = w_head[ENTRY_W-1:STATUS_W];
  assign rd_status = w_head[STATUS_W-1:0];
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop_err  = r_drop_err;

`ifdef FPU_RESULT_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: one increment per accepted push, never for a dropped result.
  // Unknown status codes (> 3) are stored but counted nowhere.
  // --------------------------------------------------------------------------
  localparam logic [STATUS_W-1:0] c_st_ovf     = STATUS_W'(0);
  localparam logic [STATUS_W-1:0] c_st_unf     = STATUS_W'(1);
  localparam logic [STATUS_W-1:0] c_st_exact   = STATUS_W'(2);
  localparam logic [STATUS_W-1:0] c_st_inexact = STATUS_W'(3);
  localparam logic [CNT_W-1:0]    c_cnt_max    = '1;
  localparam logic [CNT_W-1:0]    c_cnt_one    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt_ovf;
  logic [CNT_W-1:0] r_cnt_unf;
  logic [CNT_W-1:0] r_cnt_exact;
  logic [CNT_W-1:0] r_cnt_inexact;
  logic [CNT_W-1:0] r_cnt_zero;
  logic             w_is_zero;

  // Zero regardless of sign: every bit except the sign bit is clear.
  assign w_is_zero = (res_data[DATA_W-2:0] == '0);

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      r_cnt_ovf     <= '0;
      r_cnt_unf     <= '0;
      r_cnt_exact   <= '0;
      r_cnt_inexact <= '0;
      r_cnt_zero    <= '0;
    end else if (w_push) begin
      if ((res_status == c_st_ovf) && (r_cnt_ovf != c_cnt_max)) begin
        r_cnt_ovf <= r_cnt_ovf + c_cnt_one;
      end
      if ((res_status == c_st_unf) && (r_cnt_unf != c_cnt_max)) begin
        r_cnt_unf <= r_cnt_unf + c_cnt_one;
      end
      if ((res_status == c_st_exact) && (r_cnt_exact != c_cnt_max)) begin
        r_cnt_exact <= r_cnt_exact + c_cnt_one;
      end
      if ((res_status == c_st_inexact) && (r_cnt_inexact != c_cnt_max)) begin
        r_cnt_inexact <= r_cnt_inexact + c_cnt_one;
      end
      if (w_is_zero && (r_cnt_zero != c_cnt_max)) begin
        r_cnt_zero <= r_cnt_zero + c_cnt_one;
      end
    end
  end

  assign cnt_ovf     = r_cnt_ovf;
  assign cnt_unf     = r_cnt_unf;
  assign cnt_exact   = r_cnt_exact;
  assign cnt_inexact = r_cnt_inexact;
  assign cnt_zero    = r_cnt_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_buffer
// Purpose  : Self-checking bench for fpu_result_buffer. A table of directed
//            single-cycle vectors, hand-written multi-cycle sequences for the
//            fill/drain/drop/reset corner cases, then randomized traffic
//            compared against a queue-based reference model every cycle.
//            Statistics checks are compiled in with FPU_RESULT_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_result_buffer;

  localparam int DATA_W   = 32;
  localparam int STATUS_W = 4;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 4;   // small so saturation is reachable quickly
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                res_valid;
  logic [DATA_W-1:0]   res_data;
  logic [STATUS_W-1:0] res_status;
  logic                rd_ready;
  logic                clear_err;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [STATUS_W-1:0] rd_status;
  logic [LW-1:0]       level;
  logic                full;
  logic                empty;
  logic                drop_err;
  logic [CNT_W-1:0]    cnt_ovf, cnt_unf, cnt_exact, cnt_inexact, cnt_zero;

  always #5 clk = ~clk;

  fpu_result_buffer #(
    .DATA_W  (DATA_W),
    .STATUS_W(STATUS_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clock_100Khz(clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_status  (res_status),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_status   (rd_status),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .drop_err    (drop_err),
`ifdef FPU_RESULT_STATS_EN
    .cnt_ovf     (cnt_ovf),
    .cnt_unf     (cnt_unf),
    .cnt_exact   (cnt_exact),
    .cnt_inexact (cnt_inexact),
    .cnt_zero    (cnt_zero),
`endif
    .clear_err   (clear_err)
  );

`ifndef FPU_RESULT_STATS_EN
  assign cnt_ovf = '0; assign cnt_unf = '0; assign cnt_exact = '0;
  assign cnt_inexact = '0; assign cnt_zero = '0;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (queue of stored results) ----------------
  logic [DATA_W+STATUS_W-1:0] mq[$];
  bit                         m_drop;
  int                         m_cnt[5];   // ovf, unf, exact, inexact, zero

  task automatic model_update();
    bit pop, push;
    if (reset) begin
      mq.delete(); m_drop = 0;
      for (int k = 0; k < 5; k++) m_cnt[k] = 0;
      return;
    end
    pop  = (mq.size() > 0) && rd_ready;
    push = res_valid && ((mq.size() < DEPTH) || pop);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({res_data, res_status});
    if (res_valid && !push) m_drop = 1;
    else if (clear_err)     m_drop = 0;
    if (push) begin
      if (res_status < 4 && m_cnt[res_status] < CMAX) m_cnt[res_status]++;
      if (res_data[30:0] == 0 && m_cnt[4] < CMAX) m_cnt[4]++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [DATA_W+STATUS_W-1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".rd_valid"},  64'(rd_valid),  64'(mq.size() > 0));
    chk({tag, ".rd_data"},   64'(rd_data),   64'(head[DATA_W+STATUS_W-1:STATUS_W]));
    chk({tag, ".rd_status"}, 64'(rd_status), 64'(head[STATUS_W-1:0]));
    chk({tag, ".level"},     64'(level),     64'(mq.size()));
    chk({tag, ".full"},      64'(full),      64'(mq.size() == DEPTH));
    chk({tag, ".empty"},     64'(empty),     64'(mq.size() == 0));
    chk({tag, ".drop_err"},  64'(drop_err),  64'(m_drop));
`ifdef FPU_RESULT_STATS_EN
    chk({tag, ".cnt_ovf"},     64'(cnt_ovf),     64'(m_cnt[0]));
    chk({tag, ".cnt_unf"},     64'(cnt_unf),     64'(m_cnt[1]));
    chk({tag, ".cnt_exact"},   64'(cnt_exact),   64'(m_cnt[2]));
    chk({tag, ".cnt_inexact"}, 64'(cnt_inexact), 64'(m_cnt[3]));
    chk({tag, ".cnt_zero"},    64'(cnt_zero),    64'(m_cnt[4]));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic rst, input logic vld, input logic [31:0] d,
                        input logic [3:0] st, input logic rdy, input logic clr);
    reset = rst; res_valid = vld; res_data = d; res_status = st;
    rd_ready = rdy; clear_err = clr;
  endtask

  // Model sees the same inputs the DUT samples; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, vld;
    logic [31:0] d;
    logic [3:0]  st;
    logic        rdy, clr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [3:0]  el;
    logic        edrop;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Row: reset, res_valid, data, status, rd_ready, clear_err
    //      -> rd_valid, rd_data, rd_status, level, drop_err after the edge
    tbl[0] = '{1'b1, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h4000_0000, 4'd2, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 4'd2, 4'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         4'd0, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0};
    // push into empty with rd_ready high: no pop that cycle
    tbl[3] = '{1'b0, 1'b1, 32'h3FE0_0000, 4'd3, 1'b1, 1'b0, 1'b1, 32'h3FE0_0000, 4'd3, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         4'd0, 1'b0, 1'b0, 1'b1, 32'h3FE0_0000, 4'd3, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,         4'd0, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0};

    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].st, tbl[i].rdy, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d.rd_valid", i),  64'(rd_valid),  64'(tbl[i].ev));
      chk($sformatf("tbl%0d.rd_data", i),   64'(rd_data),   64'(tbl[i].ed));
      chk($sformatf("tbl%0d.rd_status", i), 64'(rd_status), 64'(tbl[i].es));
      chk($sformatf("tbl%0d.level", i),     64'(level),     64'(tbl[i].el));
      chk($sformatf("tbl%0d.drop_err", i),  64'(drop_err),  64'(tbl[i].edrop));
    end

    // ---- 9 pushes into DEPTH=8: last one dropped ----
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, 32'h1000_0000 + 32'(i), 4'(i % 4), 0, 0);
      tick();
    end
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.level", 64'(level), 64'd8);
    chk("fill.drop_err", 64'(drop_err), 64'd1);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 1, 0);
      #0;
      chk($sformatf("drain%0d.data", i), 64'(rd_data), 64'(32'h1000_0000 + 32'(i)));
      tick();
    end
    chk("drain.empty", 64'(empty), 64'd1);
    chk("drain.rd_data_zero", 64'(rd_data), 64'd0);
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    chk("clear_err", 64'(drop_err), 64'd0);

    // ---- full, then push with concurrent pop ----
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h2000_0000 + 32'(i), 4'd3, 0, 0);
      tick();
    end
    set_in(0, 1, 32'h4010_0000, 4'd2, 1, 0);
    tick();
    chk("fullpp.level", 64'(level), 64'd8);
    chk("fullpp.full", 64'(full), 64'd1);
    chk("fullpp.drop_err", 64'(drop_err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 1, 0);
      #0;
      chk($sformatf("fullpp.drain%0d", i), 64'(rd_data),
          64'((i < 7) ? 32'h2000_0001 + 32'(i) : 32'h4010_0000));
      tick();
    end
    chk("fullpp.empty", 64'(empty), 64'd1);

`ifdef FPU_RESULT_STATS_EN
    // ---- statistics and saturation ----
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 32'h0000_0000, 4'd2, 1, 0); tick();
    set_in(0, 1, 32'h8000_0000, 4'd2, 1, 0); tick();
    set_in(0, 1, 32'h7FE0_0000, 4'd0, 1, 0); tick();
    set_in(0, 1, 32'h7FE0_0000, 4'd9, 1, 0); tick();   // unknown code: stored, not counted
    set_in(0, 0, 0, 0, 1, 0); tick();
    chk("stats.exact", 64'(cnt_exact), 64'd2);
    chk("stats.zero", 64'(cnt_zero), 64'd2);
    chk("stats.ovf", 64'(cnt_ovf), 64'd1);
    chk("stats.unf", 64'(cnt_unf), 64'd0);
    chk("stats.inexact", 64'(cnt_inexact), 64'd0);
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, 32'h0, 4'd2, 1, 0); tick();
    end
    chk("sat.exact", 64'(cnt_exact), 64'(CMAX));
    chk("sat.zero", 64'(cnt_zero), 64'(CMAX));
    chk("sat.ovf", 64'(cnt_ovf), 64'd1);
`endif

    // ---- reset mid-stream with level 5 and drop_err set ----
    set_in(0, 0, 0, 0, 1, 0); tick(); tick();
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, 32'h3000_0000 + 32'(i), 4'd1, 0, 0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 0); tick();
    end
    chk("mid.level5", 64'(level), 64'd5);
    chk("mid.drop_set", 64'(drop_err), 64'd1);
    set_in(1, 1, 32'h5555_0000, 4'd2, 1, 0);
    tick();
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.level", 64'(level), 64'd0);
    chk("rst.rd_valid", 64'(rd_valid), 64'd0);
    chk("rst.rd_data", 64'(rd_data), 64'd0);
    chk("rst.rd_status", 64'(rd_status), 64'd0);
    chk("rst.drop_err", 64'(drop_err), 64'd0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.cnt", 64'({cnt_ovf, cnt_unf, cnt_exact, cnt_inexact, cnt_zero}), 64'd0);

    // ---- randomized traffic against the model ----
    for (int w = 0; w < 10; w++) begin
      int rdy_pct;
      rdy_pct = (w % 3 == 0) ? 15 : ((w % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 200; c++) begin
        logic [31:0] d;
        case ($urandom_range(0, 3))
          0:       d = 32'h0000_0000;
          1:       d = 32'h8000_0000;
          default: d = $urandom;
        endcase
        set_in(($urandom_range(0, 499) == 0),
               ($urandom_range(0, 99) < 55), d, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 99) < rdy_pct),
               ($urandom_range(0, 19) == 0));
        tick();
        check_model($sformatf("rnd%0d_%0d", w, c));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
